// File: rtl/csr_unit_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csr_unit_timer: LoongArch CSR file with constant timer, interrupts, ERTN |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module csr_unit_timer #(
  parameter int          NUM_SAVE = 4,
  parameter int          TIMER_W  = 32,
  parameter logic [31:0] TID_RST  = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] csr_rnum,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [13:0] csr_wnum,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  output logic [31:0] ex_entry,
  output logic [31:0] era_out,
  output logic        has_int
);
  localparam logic [13:0] CSR_CRMD   = 14'h00;
  localparam logic [13:0] CSR_PRMD   = 14'h01;
  localparam logic [13:0] CSR_ECFG   = 14'h04;
  localparam logic [13:0] CSR_ESTAT  = 14'h05;
  localparam logic [13:0] CSR_ERA    = 14'h06;
  localparam logic [13:0] CSR_BADV   = 14'h07;
  localparam logic [13:0] CSR_EENTRY = 14'h0C;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;
  localparam logic [5:0]  ECODE_ADEF = 6'h08;
  localparam logic [5:0]  ECODE_ALE  = 6'h09;
  localparam logic [12:0] ECFG_WMASK = 13'h1BFF;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_EXC   = 2'd1,
    ACT_ERTN  = 2'd2,
    ACT_WRITE = 2'd3
  } act_t;

  act_t               act;
  logic [2:0]         crmd;
  logic [2:0]         prmd;
  logic [12:0]        ecfg;
  logic [1:0]         is_sw;
  logic [7:0]         is_hw;
  logic               is_timer;
  logic               is_ipi;
  logic [5:0]         ecode;
  logic [8:0]         esubcode;
  logic [31:0]        era;
  logic [31:0]        badv;
  logic [25:0]        eentry;
  logic [31:0]        tid;
  logic [31:0]        save [NUM_SAVE];
  logic [TIMER_W-1:0] tcfg;
  logic [TIMER_W-1:0] tval;
  logic [TIMER_W-1:0] tcfg_new;
  logic [TIMER_W-1:0] tval_next;
  logic               tcfg_wr;
  logic               ticlr_hit;
  logic               timer_set;
  logic [12:0]        int_vec;

  // Exception beats ERTN beats a CSR write; the loser of the same cycle is dropped.
  always_comb begin
    act = ACT_NONE;
    if (wb_ex)           act = ACT_EXC;
    else if (ertn_flush) act = ACT_ERTN;
    else if (csr_we)     act = ACT_WRITE;
  end

  assign tcfg_wr   = (act == ACT_WRITE) && (csr_wnum == CSR_TCFG);
  assign ticlr_hit = (act == ACT_WRITE) && (csr_wnum == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];
  assign tcfg_new  = (tcfg & ~csr_wmask[TIMER_W-1:0]) | (csr_wvalue[TIMER_W-1:0] & csr_wmask[TIMER_W-1:0]);

  always_comb begin
    tval_next = tval;
    timer_set = 1'b0;
    if (tcfg_wr) begin
      if (tcfg_new[0]) tval_next = {tcfg_new[TIMER_W-1:2], 2'b00};
    end else if (tcfg[0]) begin
      if (tval != '0) begin
        tval_next = tval - TIMER_W'(1);
        timer_set = (tval == TIMER_W'(1));
      end else if (tcfg[1]) begin
        tval_next = {tcfg[TIMER_W-1:2], 2'b00};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crmd     <= '0;
      prmd     <= '0;
      ecfg     <= '0;
      is_sw    <= '0;
      is_hw    <= '0;
      is_timer <= 1'b0;
      is_ipi   <= 1'b0;
      ecode    <= '0;
      esubcode <= '0;
      era      <= '0;
      badv     <= '0;
      eentry   <= '0;
      tid      <= TID_RST;
      tcfg     <= '0;
      tval     <= '0;
      for (int i = 0; i < NUM_SAVE; i++) save[i] <= '0;
    end else begin
      is_hw  <= hw_int_in;
      is_ipi <= ipi_int_in;
      tval   <= tval_next;
      // A timer expiry on the same edge as a TICLR write keeps the interrupt pending.
      if (timer_set)      is_timer <= 1'b1;
      else if (ticlr_hit) is_timer <= 1'b0;
      case (act)
        ACT_EXC: begin
          prmd     <= crmd;
          crmd     <= 3'b000;
          era      <= wb_pc;
          ecode    <= wb_ecode;
          esubcode <= wb_esubcode;
          if (wb_ecode == ECODE_ADEF)     badv <= wb_pc;
          else if (wb_ecode == ECODE_ALE) badv <= wb_vaddr;
        end
        ACT_ERTN: crmd <= prmd;
        ACT_WRITE: begin
          case (csr_wnum)
            CSR_CRMD:   crmd   <= (crmd & ~csr_wmask[2:0]) | (csr_wvalue[2:0] & csr_wmask[2:0]);
            CSR_PRMD:   prmd   <= (prmd & ~csr_wmask[2:0]) | (csr_wvalue[2:0] & csr_wmask[2:0]);
            CSR_ECFG:   ecfg   <= (ecfg & ~(csr_wmask[12:0] & ECFG_WMASK))
                                  | (csr_wvalue[12:0] & csr_wmask[12:0] & ECFG_WMASK);
            CSR_ESTAT:  is_sw  <= (is_sw & ~csr_wmask[1:0]) | (csr_wvalue[1:0] & csr_wmask[1:0]);
            CSR_ERA:    era    <= (era & ~csr_wmask) | (csr_wvalue & csr_wmask);
            CSR_BADV:   badv   <= (badv & ~csr_wmask) | (csr_wvalue & csr_wmask);
            CSR_EENTRY: eentry <= (eentry & ~csr_wmask[31:6]) | (csr_wvalue[31:6] & csr_wmask[31:6]);
            CSR_TID:    tid    <= (tid & ~csr_wmask) | (csr_wvalue & csr_wmask);
            CSR_TCFG:   tcfg   <= tcfg_new;
            default: ;
          endcase
          for (int i = 0; i < NUM_SAVE; i++) begin
            if (csr_wnum == CSR_SAVE0 + 14'(i))
              save[i] <= (save[i] & ~csr_wmask) | (csr_wvalue & csr_wmask);
          end
        end
        default: ;
      endcase
    end
  end

  assign int_vec = {is_ipi, is_timer, 1'b0, is_hw, is_sw};

  always_comb begin
    csr_rvalue = '0;
    case (csr_rnum)
      CSR_CRMD:   csr_rvalue = {28'h0, 1'b1, crmd};
      CSR_PRMD:   csr_rvalue = {29'h0, prmd};
      CSR_ECFG:   csr_rvalue = {19'h0, ecfg};
      CSR_ESTAT:  csr_rvalue = {1'b0, esubcode, ecode, 3'b000, int_vec};
      CSR_ERA:    csr_rvalue = era;
      CSR_BADV:   csr_rvalue = badv;
      CSR_EENTRY: csr_rvalue = {eentry, 6'b0};
      CSR_TID:    csr_rvalue = tid;
      CSR_TCFG:   csr_rvalue = 32'(tcfg);
      CSR_TVAL:   csr_rvalue = 32'(tval);
      default: begin
        for (int i = 0; i < NUM_SAVE; i++) begin
          if (csr_rnum == CSR_SAVE0 + 14'(i)) csr_rvalue = save[i];
        end
      end
    endcase
  end

  assign ex_entry = {eentry, 6'b0};
  assign era_out  = era;
  assign has_int  = crmd[2] & (|(ecfg & int_vec));

endmodule
`default_nettype wire

// File: tb/tb_csr_unit_timer.sv
`default_nettype none
// Bench for csr_unit_timer: directed scenarios then random traffic, checked against a register-map model.
module tb_csr_unit_timer;
  localparam int          NS    = 4;
  localparam int          TW    = 16;
  localparam logic [31:0] TIDR  = 32'h0000_005A;
  localparam logic [31:0] TMASK = 32'h0000_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] csr_rnum = '0;
  logic [31:0] csr_rvalue;
  logic        csr_we = 1'b0;
  logic [13:0] csr_wnum = '0;
  logic [31:0] csr_wmask = '0;
  logic [31:0] csr_wvalue = '0;
  logic [7:0]  hw_int_in = '0;
  logic        ipi_int_in = 1'b0;
  logic        wb_ex = 1'b0;
  logic [5:0]  wb_ecode = '0;
  logic [8:0]  wb_esubcode = '0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_vaddr = '0;
  logic        ertn_flush = 1'b0;
  logic [31:0] ex_entry;
  logic [31:0] era_out;
  logic        has_int;

  csr_unit_timer #(.NUM_SAVE(NS), .TIMER_W(TW), .TID_RST(TIDR)) dut (
    .clk(clk), .reset(reset), .csr_rnum(csr_rnum), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wnum(csr_wnum), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
    .ex_entry(ex_entry), .era_out(era_out), .has_int(has_int)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] regs [int];
  logic [13:0] addrs [19] = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0C, 14'h30, 14'h31,
                              14'h32, 14'h33, 14'h34, 14'h3F, 14'h40, 14'h41, 14'h42, 14'h44, 14'h02, 14'h100};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    regs.delete();
    regs[0] = 32'h8;
    foreach (addrs[k]) if (addrs[k] != 14'h00) regs[int'(addrs[k])] = 32'h0;
    regs['h40] = TIDR;
  endfunction

  // Architectural writable-field mask of each CSR address.
  function automatic logic [31:0] wmask_of(input int a);
    case (a)
      'h00, 'h01:        return 32'h0000_0007;
      'h04:              return 32'h0000_1BFF;
      'h05:              return 32'h0000_0003;
      'h06, 'h07, 'h40:  return 32'hFFFF_FFFF;
      'h0C:              return 32'hFFFF_FFC0;
      'h41:              return TMASK;
      default:           return (a >= 'h30 && a < 'h30 + NS) ? 32'hFFFF_FFFF : 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a >= 'h30 + NS && a <= 'h3F) return 32'h0;
    if (a == 'h44 || !regs.exists(a)) return 32'h0;
    return regs[a];
  endfunction

  function automatic void model_step();
    logic [31:0] nx [int];
    logic [31:0] es, tc, tv, wmk, cur;
    logic do_wr, t_set, t_clr;
    int a;
    nx    = regs;
    a     = int'(csr_wnum);
    do_wr = csr_we && !wb_ex && !ertn_flush;
    t_clr = do_wr && a == 'h44 && csr_wmask[0] && csr_wvalue[0];
    wmk   = wmask_of(a) & csr_wmask;
    if (do_wr && wmk != 0) begin
      cur   = regs[a];
      nx[a] = (cur & ~wmk) | (csr_wvalue & wmk);
    end
    if (wb_ex) begin
      nx[1] = regs[0] & 32'h7;
      nx[0] = regs[0] & ~32'h7;
      nx[6] = wb_pc;
      if (wb_ecode == 6'h08) nx[7] = wb_pc;
      else if (wb_ecode == 6'h09) nx[7] = wb_vaddr;
    end else if (ertn_flush) begin
      nx[0] = (regs[0] & ~32'h7) | (regs[1] & 32'h7);
    end
    tc    = nx['h41];
    tv    = regs['h42];
    t_set = 1'b0;
    if (do_wr && a == 'h41) begin
      if (tc[0]) tv = tc & 32'hFFFF_FFFC;
    end else if (tc[0]) begin
      if (tv != 0) begin
        tv    = tv - 1;
        t_set = (tv == 0);
      end else if (tc[1]) begin
        tv = tc & 32'hFFFF_FFFC;
      end
    end
    nx['h42] = tv;
    es        = nx[5];
    es[9:2]   = hw_int_in;
    es[12]    = ipi_int_in;
    if (t_set) es[11] = 1'b1;
    else if (t_clr) es[11] = 1'b0;
    if (wb_ex) begin
      es[21:16] = wb_ecode;
      es[30:22] = wb_esubcode;
    end
    nx[5] = es;
    regs  = nx;
  endfunction

  task automatic tick();
    logic [31:0] c, e, s;
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    c = regs[0];
    e = regs[4];
    s = regs[5];
    chk("has_int", {31'b0, has_int}, {31'b0, c[2] && ((e & s & 32'h1FFF) != 0)});
    chk("ex_entry", ex_entry, regs['h0C]);
    chk("era_out", era_out, regs[6]);
    chk($sformatf("read_%0h", csr_rnum), csr_rvalue, m_read(int'(csr_rnum)));
  endtask

  task automatic idle();
    csr_we = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0;
    hw_int_in = '0; ipi_int_in = 1'b0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] v, input logic [31:0] m);
    csr_we = 1'b1; csr_wnum = a; csr_wvalue = v; csr_wmask = m;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic rd_const(input logic [13:0] a, input logic [31:0] exp, input string tag);
    csr_rnum = a;
    tick();
    chk(tag, csr_rvalue, exp);
  endtask

  initial begin
    logic [31:0] seq [9] = '{32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd8};
    idle();
    tick();
    reset = 1'b0;

    foreach (addrs[k])
      rd_const(addrs[k], (addrs[k] == 14'h00) ? 32'h8 : (addrs[k] == 14'h40) ? TIDR : 32'h0, "reset_read");
    chk("reset_has_int", {31'b0, has_int}, 32'h0);

    csr_rnum = 14'h05;
    wr(14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("estat_ro_fields", csr_rvalue, 32'h0000_0003);
    csr_rnum = 14'h04;
    wr(14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("ecfg_bit10_ro", csr_rvalue, 32'h0000_1BFF);
    wr(14'h05, 32'h0, 32'hFFFF_FFFF);
    wr(14'h04, 32'h0000_0800, 32'hFFFF_FFFF);
    csr_rnum = 14'h00;
    wr(14'h00, 32'hFFFF_FFFC, 32'h0000_0007);
    chk("crmd_ie", csr_rvalue, 32'h0000_000C);

    // Periodic timer, InitV=2: 8 counts down to 0, then reloads.
    csr_rnum = 14'h42;
    wr(14'h41, 32'h0000_000B, 32'hFFFF_FFFF);
    chk("tval_load", csr_rvalue, 32'd8);
    foreach (seq[k]) begin
      tick();
      chk("tval_seq", csr_rvalue, seq[k]);
      if (seq[k] == 32'd1) chk("has_int_before_expiry", {31'b0, has_int}, 32'h0);
      if (seq[k] == 32'd0) chk("has_int_expiry", {31'b0, has_int}, 32'h1);
    end
    wr(14'h44, 32'h1, 32'h1);
    chk("ticlr_clears", {31'b0, has_int}, 32'h0);
    for (int k = 0; k < 20 && regs['h42] != 32'd1; k++) tick();
    chk("tval_at_one", csr_rvalue, 32'd1);
    wr(14'h44, 32'h1, 32'h1);
    chk("set_beats_ticlr", {31'b0, has_int}, 32'h1);
    wr(14'h41, 32'h0, 32'hFFFF_FFFF);
    wr(14'h44, 32'h1, 32'h1);
    wr(14'h00, 32'h0, 32'h7);

    csr_rnum = 14'h0C;
    wr(14'h0C, 32'h1C00_8123, 32'hFFFF_FFFF);
    chk("ex_entry_align", ex_entry, 32'h1C00_8100);

    // ALE exception from PLV3/IE=1 with a same-cycle SAVE0 write.
    wr(14'h00, 32'h7, 32'h7);
    wb_ex = 1'b1; wb_ecode = 6'h09; wb_esubcode = 9'h003;
    wb_pc = 32'h1C00_0100; wb_vaddr = 32'h1234_5677;
    csr_we = 1'b1; csr_wnum = 14'h30; csr_wvalue = 32'hDEAD_BEEF; csr_wmask = 32'hFFFF_FFFF;
    csr_rnum = 14'h30;
    tick();
    chk("save0_dropped", csr_rvalue, 32'h0);
    idle();
    rd_const(14'h01, 32'h7, "prmd_after_ex");
    rd_const(14'h00, 32'h8, "crmd_after_ex");
    rd_const(14'h06, 32'h1C00_0100, "era_after_ex");
    rd_const(14'h07, 32'h1234_5677, "badv_ale");
    rd_const(14'h05, 32'h00C9_0000, "estat_codes");
    chk("era_out_ex", era_out, 32'h1C00_0100);

    ertn_flush = 1'b1;
    csr_we = 1'b1; csr_wnum = 14'h31; csr_wvalue = 32'h55; csr_wmask = 32'hFFFF_FFFF;
    csr_rnum = 14'h00;
    tick();
    chk("crmd_after_ertn", csr_rvalue, 32'hF);
    idle();
    rd_const(14'h31, 32'h0, "save1_dropped");

    wb_ex = 1'b1; ertn_flush = 1'b1; wb_ecode = 6'h08; wb_esubcode = 9'h0;
    wb_pc = 32'h1C00_0200; wb_vaddr = 32'h0000_AAAA;
    csr_rnum = 14'h00;
    tick();
    chk("ex_over_ertn", csr_rvalue, 32'h8);
    idle();
    rd_const(14'h01, 32'h7, "prmd_ex_over_ertn");
    rd_const(14'h07, 32'h1C00_0200, "badv_adef");

    wr(14'h00, 32'h4, 32'h7);
    wr(14'h04, 32'h4, 32'hFFFF_FFFF);
    hw_int_in = 8'h01;
    #1;
    chk("hw_int_not_yet", {31'b0, has_int}, 32'h0);
    tick();
    chk("hw_int_sampled", {31'b0, has_int}, 32'h1);
    hw_int_in = 8'h00;
    tick();

    // Async reset while the timer counts.
    csr_rnum = 14'h42;
    wr(14'h41, 32'h0000_0041, 32'hFFFF_FFFF);
    repeat (5) tick();
    chk("tval_running", csr_rvalue, 32'd59);
    #2;
    reset = 1'b1;
    #1;
    chk("async_tval", csr_rvalue, 32'h0);
    chk("async_era", era_out, 32'h0);
    chk("async_entry", ex_entry, 32'h0);
    csr_rnum = 14'h00;
    #1;
    chk("async_crmd", csr_rvalue, 32'h8);
    tick();
    reset = 1'b0;
    csr_rnum = 14'h42;
    repeat (2) tick();

    for (int n = 0; n < 600; n++) begin
      csr_we      = ($urandom_range(0, 1) == 1);
      csr_wnum    = addrs[$urandom_range(0, 18)];
      csr_wmask   = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
      csr_wvalue  = (csr_wnum == 14'h41) ? 32'($urandom_range(0, 63)) : $urandom;
      wb_ex       = ($urandom_range(0, 9) == 0);
      ertn_flush  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0:       wb_ecode = 6'h08;
        1:       wb_ecode = 6'h09;
        default: wb_ecode = 6'($urandom);
      endcase
      wb_esubcode = 9'($urandom);
      wb_pc       = $urandom;
      wb_vaddr    = $urandom;
      hw_int_in   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h0;
      ipi_int_in  = ($urandom_range(0, 15) == 0);
      csr_rnum    = addrs[$urandom_range(0, 18)];
      tick();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
